softmax_frame_ctrl_16: RTL and testbench

//  Frame-level sequencer wrapped around the 16-bit paired softmax core. Sits between the external
//  AXI4-Stream ports and the core's AXIS ports. Admits one vector (frame) at a time and caps its

---
 rtl/softmax_ctrl_pkg.sv | 17 +
 rtl/softmax_watchdog.sv | 40 ++++
 rtl/softmax_frame_ctrl_16.sv | 215 +++++++++++++++++++++
 tb/tb_softmax_frame_ctrl_16.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/softmax_ctrl_pkg.sv
// Shared types and widths for the softmax frame controller.
// State encoding, beat/frame counter widths, watchdog width.
package softmax_ctrl_pkg;

  localparam int BEAT_W      = 8;
  localparam int FRAME_CNT_W = 16;
  localparam int WD_W        = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DISC,
    ST_PROC,
    ST_FLUSH
  } state_e;

endpackage

// File: rtl/softmax_watchdog.sv
// Loadable down-counter with enable; expired_o while enabled at zero.
// Ports: clk, rst_n, load_i/load_val_i, en_i, expired_o.
module softmax_watchdog
  import softmax_ctrl_pkg::*;
#(
  parameter int W = WD_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         expired_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Independent of load_i so the parent can choose
  // load-vs-expire without a combinational loop.
  assign expired_o = en_i && (cnt_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/softmax_frame_ctrl_16.sv
// Frame sequencer around the paired softmax core: admits one frame,
// caps its length, matches beat counts, watchdogs the core, flushes it.
// Ports: s_axis_* upstream, core_s_* to core, core_m_* from core,
// m_axis_* downstream, core_rst_n_o, busy/done/error status, frame count.
module softmax_frame_ctrl_16
  import softmax_ctrl_pkg::*;
#(
  parameter int DATA_SIZE      = 16,
  parameter int MAX_BEATS      = 128,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int FLUSH_CYCLES   = 4
) (
  input  logic                     axi_clock_i,
  input  logic                     axi_reset_n_i,
  input  logic                     s_axis_valid_i,
  input  logic                     s_axis_last_i,
  input  logic [2*DATA_SIZE-1:0]   s_axis_data_i,
  output logic                     s_axis_ready_o,
  output logic                     core_s_valid_o,
  output logic                     core_s_last_o,
  output logic [2*DATA_SIZE-1:0]   core_s_data_o,
  input  logic                     core_s_ready_i,
  input  logic                     core_m_valid_i,
  input  logic                     core_m_last_i,
  input  logic [2*DATA_SIZE-1:0]   core_m_data_i,
  output logic                     core_m_ready_o,
  output logic                     m_axis_valid_o,
  output logic                     m_axis_last_o,
  output logic [2*DATA_SIZE-1:0]   m_axis_data_o,
  input  logic                     m_axis_ready_i,
  output logic                     core_rst_n_o,
  output logic                     busy_o,
  output logic                     frame_done_o,
  output logic                     err_len_o,
  output logic                     err_cnt_o,
  output logic                     err_timeout_o,
  input  logic                     err_clear_i,
  output logic [FRAME_CNT_W-1:0]   frame_count_o
);

  localparam logic [BEAT_W-1:0] MAX_B   = BEAT_W'(MAX_BEATS);
  localparam logic [WD_W-1:0]   TO_LOAD = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [WD_W-1:0]   FL_LOAD = WD_W'(FLUSH_CYCLES - 1);

  state_e                   state_q, state_d;
  logic [BEAT_W-1:0]        in_cnt_q, in_cnt_d;
  logic [BEAT_W-1:0]        out_cnt_q, out_cnt_d;
  logic                     err_len_q, err_len_d;
  logic                     err_cnt_q, err_cnt_d;
  logic                     err_to_q, err_to_d;
  logic                     frame_done_q, frame_done_d;
  logic [FRAME_CNT_W-1:0]   frame_count_q, frame_count_d;

  logic              s_ready, core_s_valid, core_s_last;
  logic              m_valid, m_last, core_m_ready;
  logic              s_hs, m_hs, at_cap;
  logic              ev_len, ev_cnt, ev_to;
  logic [BEAT_W-1:0] in_next;
  logic              wd_load, wd_en, wd_expired;
  logic [WD_W-1:0]   wd_val;

  softmax_watchdog #(
    .W (WD_W)
  ) u_wd (
    .clk        (axi_clock_i),
    .rst_n      (axi_reset_n_i),
    .load_i     (wd_load),
    .load_val_i (wd_val),
    .en_i       (wd_en),
    .expired_o  (wd_expired)
  );

  always_comb begin
    state_d       = state_q;
    in_cnt_d      = in_cnt_q;
    out_cnt_d     = out_cnt_q;
    frame_done_d  = 1'b0;
    frame_count_d = frame_count_q;
    ev_len        = 1'b0;
    ev_cnt        = 1'b0;
    ev_to         = 1'b0;
    wd_load       = 1'b0;
    wd_val        = TO_LOAD;
    wd_en         = 1'b0;
    s_ready       = 1'b0;
    core_s_valid  = 1'b0;
    core_s_last   = 1'b0;
    m_valid       = 1'b0;
    m_last        = 1'b0;
    core_m_ready  = 1'b0;
    s_hs          = 1'b0;
    m_hs          = 1'b0;
    in_next = (state_q == ST_IDLE) ? BEAT_W'(1)
                                   : in_cnt_q + 1'b1;
    at_cap  = (in_next == MAX_B);

    // Output path open in LOAD/DISC/PROC only.
    if ((state_q == ST_LOAD) || (state_q == ST_DISC) ||
        (state_q == ST_PROC)) begin
      m_valid      = core_m_valid_i;
      m_last       = core_m_last_i;
      core_m_ready = m_axis_ready_i;
      m_hs         = core_m_valid_i && m_axis_ready_i;
      if (m_hs) begin
        out_cnt_d = out_cnt_q + 1'b1;
      end
    end

    unique case (state_q)
      ST_IDLE, ST_LOAD: begin
        if (state_q == ST_IDLE) begin
          out_cnt_d = '0;
        end
        s_ready      = core_s_ready_i;
        core_s_valid = s_axis_valid_i;
        // Truncate by forcing last on the cap beat.
        core_s_last  = s_axis_last_i || at_cap;
        s_hs         = s_axis_valid_i && core_s_ready_i;
        if (s_hs) begin
          in_cnt_d = in_next;
          if (s_axis_last_i) begin
            state_d = ST_PROC;
            wd_load = 1'b1;
          end else if (at_cap) begin
            ev_len  = 1'b1;
            state_d = ST_DISC;
          end else begin
            state_d = ST_LOAD;
          end
        end
      end
      ST_DISC: begin
        s_ready = 1'b1;
        if (s_axis_valid_i && s_axis_last_i) begin
          state_d = ST_PROC;
          wd_load = 1'b1;
        end
      end
      ST_PROC: begin
        wd_en = 1'b1;
        if (m_hs) begin
          wd_load = 1'b1;
          if (core_m_last_i) begin
            frame_done_d  = 1'b1;
            frame_count_d = frame_count_q + 1'b1;
            ev_cnt  = (out_cnt_q + 1'b1) != in_cnt_q;
            state_d = ST_IDLE;
          end
        end else if (wd_expired) begin
          ev_to   = 1'b1;
          wd_load = 1'b1;
          wd_val  = FL_LOAD;
          state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        wd_en = 1'b1;
        if (wd_expired) begin
          state_d   = ST_IDLE;
          in_cnt_d  = '0;
          out_cnt_d = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A new error in the clearing cycle keeps its flag set.
    err_len_d = (err_len_q && !err_clear_i) || ev_len;
    err_cnt_d = (err_cnt_q && !err_clear_i) || ev_cnt;
    err_to_d  = (err_to_q  && !err_clear_i) || ev_to;
  end

  always_ff @(posedge axi_clock_i or negedge axi_reset_n_i) begin
    if (!axi_reset_n_i) begin
      state_q       <= ST_IDLE;
      in_cnt_q      <= '0;
      out_cnt_q     <= '0;
      err_len_q     <= 1'b0;
      err_cnt_q     <= 1'b0;
      err_to_q      <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      in_cnt_q      <= in_cnt_d;
      out_cnt_q     <= out_cnt_d;
      err_len_q     <= err_len_d;
      err_cnt_q     <= err_cnt_d;
      err_to_q      <= err_to_d;
      frame_done_q  <= frame_done_d;
      frame_count_q <= frame_count_d;
    end
  end

  // Handshake outputs are forced low while reset is asserted,
  // since IDLE would otherwise pass core_s_ready_i through.
  assign s_axis_ready_o = s_ready      && axi_reset_n_i;
  assign core_s_valid_o = core_s_valid && axi_reset_n_i;
  assign core_m_ready_o = core_m_ready && axi_reset_n_i;
  assign m_axis_valid_o = m_valid      && axi_reset_n_i;
  assign core_s_last_o  = core_s_last;
  assign m_axis_last_o  = m_last;
  assign core_s_data_o  = s_axis_data_i;
  assign m_axis_data_o  = core_m_data_i;
  assign core_rst_n_o   = (state_q != ST_FLUSH);
  assign busy_o         = (state_q != ST_IDLE);
  assign frame_done_o   = frame_done_q;
  assign err_len_o      = err_len_q;
  assign err_cnt_o      = err_cnt_q;
  assign err_timeout_o  = err_to_q;
  assign frame_count_o  = frame_count_q;

endmodule

// File: tb/tb_softmax_frame_ctrl_16.sv
// Bench for softmax_frame_ctrl_16: directed frame table plus
// sequences for clear/error overlap, reset, watchdog and random traffic.
module tb_softmax_frame_ctrl_16;

  localparam int BW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          s_axis_valid_i, s_axis_last_i, s_axis_ready_o;
  logic [BW-1:0] s_axis_data_i;
  logic          core_s_valid_o, core_s_last_o, core_s_ready_i;
  logic [BW-1:0] core_s_data_o;
  logic          core_m_valid_i, core_m_last_i, core_m_ready_o;
  logic [BW-1:0] core_m_data_i;
  logic          m_axis_valid_o, m_axis_last_o, m_axis_ready_i;
  logic [BW-1:0] m_axis_data_o;
  logic          core_rst_n_o, busy_o, frame_done_o;
  logic          err_len_o, err_cnt_o, err_timeout_o, err_clear_i;
  logic [15:0]   frame_count_o;

  always #5 clk = ~clk;

  softmax_frame_ctrl_16 #(
    .DATA_SIZE      (16),
    .MAX_BEATS      (128),
    .TIMEOUT_CYCLES (4096),
    .FLUSH_CYCLES   (4)
  ) dut (
    .axi_clock_i    (clk),
    .axi_reset_n_i  (rst_n),
    .s_axis_valid_i (s_axis_valid_i),
    .s_axis_last_i  (s_axis_last_i),
    .s_axis_data_i  (s_axis_data_i),
    .s_axis_ready_o (s_axis_ready_o),
    .core_s_valid_o (core_s_valid_o),
    .core_s_last_o  (core_s_last_o),
    .core_s_data_o  (core_s_data_o),
    .core_s_ready_i (core_s_ready_i),
    .core_m_valid_i (core_m_valid_i),
    .core_m_last_i  (core_m_last_i),
    .core_m_data_i  (core_m_data_i),
    .core_m_ready_o (core_m_ready_o),
    .m_axis_valid_o (m_axis_valid_o),
    .m_axis_last_o  (m_axis_last_o),
    .m_axis_data_o  (m_axis_data_o),
    .m_axis_ready_i (m_axis_ready_i),
    .core_rst_n_o   (core_rst_n_o),
    .busy_o         (busy_o),
    .frame_done_o   (frame_done_o),
    .err_len_o      (err_len_o),
    .err_cnt_o      (err_cnt_o),
    .err_timeout_o  (err_timeout_o),
    .err_clear_i    (err_clear_i),
    .frame_count_o  (frame_count_o)
  );

  typedef struct {
    int n_in;
    int emit;
    int exp_core;
    int exp_last;
    int exp_out;
    bit exp_len;
    bit exp_cnt;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;

  logic [BW-1:0] src[$];
  logic [BW-1:0] cq[$];
  int src_idx, clear_at, emit_req, emit_n, emit_idx, fid;
  int core_cnt, core_last, out_cnt, fd_cnt;
  int proc_cyc, rstlow_cyc, exp_fc;
  bit src_done, src_hold, rnd_mode, core_go;
  bit went_busy, done_flag, clr_now;

  task automatic chk(string name, logic [BW-1:0] act,
                     logic [BW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d",
               name, act, exp);
    end
  endtask

  task automatic start_frame(int n, int emit, bit rnd);
    src.delete();
    cq.delete();
    fid++;
    for (int i = 0; i < n; i++) begin
      src.push_back(BW'((fid << 16) | i));
    end
    src_idx = 0;   src_done = 0;  src_hold = 0;
    rnd_mode = rnd; emit_req = emit; core_go = 0;
    emit_n = 0;    emit_idx = 0;  core_cnt = 0;
    core_last = -1; out_cnt = 0;  fd_cnt = 0;
    proc_cyc = 0;  rstlow_cyc = 0;
    went_busy = 0; done_flag = 0;
  endtask

  task automatic step();
    @(negedge clk);
    if (!src_done && src_idx < src.size()) begin
      if (!src_hold) begin
        src_hold = rnd_mode ? ($urandom_range(0, 9) < 7) : 1'b1;
      end
    end else begin
      src_hold = 0;
    end
    s_axis_valid_i = src_hold;
    s_axis_data_i  = (src_idx < src.size()) ? src[src_idx] : '0;
    s_axis_last_i  = (src_idx == src.size() - 1);
    err_clear_i    = clr_now ||
                     (clear_at >= 0 && src_idx == clear_at && src_hold);
    m_axis_ready_i = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    core_s_ready_i = 1'b1;
    core_m_valid_i = core_go && (emit_idx < emit_n);
    core_m_data_i  = core_m_valid_i ? ~cq[emit_idx] : '0;
    core_m_last_i  = (emit_idx == emit_n - 1);
    #4;
    if (src_done && busy_o) begin
      chk("no_input_in_proc", s_axis_ready_o, 1'b0);
      went_busy = 1;
    end
    if (src_done && busy_o && core_rst_n_o) proc_cyc++;
    if (!core_rst_n_o) rstlow_cyc++;
    if (frame_done_o) fd_cnt++;
    if (went_busy && !busy_o) done_flag = 1;
    if (core_s_valid_o && core_s_ready_i) begin
      chk("core_in_data", core_s_data_o, src[core_cnt]);
      cq.push_back(core_s_data_o);
      core_cnt++;
      if (core_s_last_o && core_last < 0) begin
        core_last = core_cnt;
        core_go   = 1;
        emit_n    = (emit_req < cq.size()) ? emit_req : cq.size();
        emit_idx  = 0;
      end
    end
    if (m_axis_valid_o && m_axis_ready_i) begin
      if (out_cnt < src.size()) begin
        chk("out_data", m_axis_data_o, ~src[out_cnt]);
      end
      chk("out_last", m_axis_last_o, out_cnt == emit_n - 1);
      out_cnt++;
    end
    if (core_m_valid_i && core_m_ready_o) emit_idx++;
    if (s_axis_valid_i && s_axis_ready_o) begin
      if (s_axis_last_i) src_done = 1;
      src_idx++;
      src_hold = 0;
    end
    if (!core_rst_n_o) begin
      cq.delete();
      core_go = 0;
    end
    @(posedge clk);
  endtask

  task automatic run_frame(int budget);
    for (int c = 0; c < budget && !done_flag; c++) step();
    chk("frame_ended", done_flag, 1'b1);
    step();
    step();
  endtask

  task automatic clear_errs();
    clr_now = 1;
    step();
    clr_now = 0;
    step();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    #20;
    @(negedge clk);
    rst_n = 1;
  endtask

  vec_t tv[5];

  initial begin
    tv[0] = '{4,   4,   4,   4,   4,   1'b0, 1'b0};
    tv[1] = '{130, 130, 128, 128, 128, 1'b1, 1'b0};
    tv[2] = '{4,   3,   4,   4,   3,   1'b0, 1'b1};
    tv[3] = '{128, 128, 128, 128, 128, 1'b0, 1'b0};
    tv[4] = '{1,   1,   1,   1,   1,   1'b0, 1'b0};

    fid = 0; clear_at = -1; clr_now = 0; exp_fc = 0;
    start_frame(0, 0, 0);
    rst_n = 0;
    s_axis_valid_i = 1; s_axis_last_i = 0; s_axis_data_i = '0;
    core_s_ready_i = 1; core_m_valid_i = 1; core_m_last_i = 0;
    core_m_data_i = '0; m_axis_ready_i = 1; err_clear_i = 0;
    #12;
    chk("rst_s_ready", s_axis_ready_o, 1'b0);
    chk("rst_core_s_valid", core_s_valid_o, 1'b0);
    chk("rst_m_valid", m_axis_valid_o, 1'b0);
    chk("rst_core_m_ready", core_m_ready_o, 1'b0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_core_rst_n", core_rst_n_o, 1'b1);
    chk("rst_frame_done", frame_done_o, 1'b0);
    chk("rst_frame_count", frame_count_o, 0);
    chk("rst_errs", {err_len_o, err_cnt_o, err_timeout_o}, 0);
    s_axis_valid_i = 0; core_m_valid_i = 0;
    @(negedge clk);
    rst_n = 1;

    for (int v = 0; v < 5; v++) begin
      clear_errs();
      chk("pre_err_len", err_len_o, 1'b0);
      chk("pre_err_cnt", err_cnt_o, 1'b0);
      start_frame(tv[v].n_in, tv[v].emit, 0);
      run_frame(1000);
      exp_fc++;
      chk("core_beats", core_cnt, tv[v].exp_core);
      chk("core_last_pos", core_last, tv[v].exp_last);
      chk("out_beats", out_cnt, tv[v].exp_out);
      chk("done_pulses", fd_cnt, 1);
      chk("frame_count", frame_count_o, exp_fc);
      chk("err_len", err_len_o, tv[v].exp_len);
      chk("err_cnt", err_cnt_o, tv[v].exp_cnt);
      chk("err_timeout", err_timeout_o, 1'b0);
      chk("idle_after", busy_o, 1'b0);
    end

    start_frame(130, 130, 0);
    run_frame(1000);
    exp_fc++;
    chk("len_set", err_len_o, 1'b1);
    clear_at = 127;
    start_frame(130, 130, 0);
    run_frame(1000);
    exp_fc++;
    clear_at = -1;
    chk("clear_vs_event_len", err_len_o, 1'b1);
    chk("clear_vs_event_fc", frame_count_o, exp_fc);

    start_frame(10, 10, 0);
    for (int i = 0; i < 4; i++) step();
    chk("mid_load_busy", busy_o, 1'b1);
    @(negedge clk);
    rst_n = 0;
    s_axis_valid_i = 1;
    #1;
    chk("arst_s_ready", s_axis_ready_o, 1'b0);
    chk("arst_core_s_valid", core_s_valid_o, 1'b0);
    chk("arst_busy", busy_o, 1'b0);
    chk("arst_err_len", err_len_o, 1'b0);
    chk("arst_frame_count", frame_count_o, 0);
    chk("arst_core_rst_n", core_rst_n_o, 1'b1);
    #20;
    s_axis_valid_i = 0;
    @(negedge clk);
    rst_n = 1;
    exp_fc = 0;

    start_frame(4, 0, 0);
    run_frame(6000);
    chk("to_proc_cycles", proc_cyc, 4096);
    chk("to_flush_cycles", rstlow_cyc, 4);
    chk("to_err", err_timeout_o, 1'b1);
    chk("to_no_done", fd_cnt, 0);
    chk("to_idle", busy_o, 1'b0);
    start_frame(4, 4, 0);
    run_frame(1000);
    exp_fc++;
    chk("after_to_out", out_cnt, 4);
    chk("after_to_done", fd_cnt, 1);
    chk("after_to_fc", frame_count_o, exp_fc);

    do_reset();
    for (int f = 0; f < 20; f++) begin
      int n;
      n = $urandom_range(1, 12);
      start_frame(n, n, 1);
      run_frame(2000);
      chk("rnd_core_beats", core_cnt, n);
      chk("rnd_out_beats", out_cnt, n);
      chk("rnd_done", fd_cnt, 1);
    end
    chk("rnd_frame_count", frame_count_o, 20);
    chk("rnd_no_errs",
        {err_len_o, err_cnt_o, err_timeout_o}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
